// File: rtl/ones_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : ones_pattern_generator
// Brief    : Streams every N-bit word with exactly K ones, in ascending order.
// Revision : 1.0
// ============================================================================
module ones_pattern_generator #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] target_count,
   input  logic         abort,
   output logic [N-1:0] pattern,
   output logic         pattern_valid,
   input  logic         pattern_ready,
   output logic         pattern_last,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int        CW     = $clog2(N + 1);
   localparam logic [N:0] c_one = (N+1)'(1);
   localparam logic [N:0] c_n   = (N+1)'(N);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]   r_state;
   logic [N-1:0] r_pattern;
   logic [N-1:0] r_top;
   logic         r_done;
   logic         r_err;

   logic         w_k_bad;
   logic [N:0]   w_low;
   logic [N:0]   w_top;
   logic [N:0]   w_x;
   logic [N:0]   w_c;
   logic [N:0]   w_r;
   logic [N:0]   w_next;
   logic [CW-1:0] w_ctz;
   logic         w_run;
   logic         w_last;

   assign w_k_bad = ({1'b0, target_count} > c_n);
   assign w_low   = (c_one << target_count) - c_one;
   assign w_top   = w_low << (c_n - {1'b0, target_count});

   // Gosper successor, one bit wider so the ripple add never overflows.
   assign w_x    = {1'b0, r_pattern};
   assign w_c    = w_x & (~w_x + c_one);
   assign w_r    = w_x + w_c;
   assign w_next = w_r | (((w_r ^ w_x) >> 2) >> w_ctz);

   always_comb begin
      w_ctz = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (r_pattern[i]) w_ctz = CW'(i);
      end
   end

   assign w_run  = (r_state == S_RUN);
   assign w_last = w_run && (r_pattern == r_top);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pattern <= '0;
         r_top     <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!abort && start) begin
                  if (w_k_bad) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state   <= S_RUN;
                     r_pattern <= w_low[N-1:0];
                     r_top     <= w_top[N-1:0];
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else if (pattern_ready) begin
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_pattern <= w_next[N-1:0];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pattern       = r_pattern;
   assign pattern_valid = w_run;
   assign busy          = w_run;
   assign pattern_last  = w_last;
   assign done          = r_done;
   assign err           = r_err;

endmodule
`default_nettype wire

// File: doc/ones_pattern_generator.md
Name: ones_pattern_generator

Overview:
- Inverse companion to the team's combinational ones-counter. Given a target ones-count K, emits every N-bit word with exactly K ones, one word per handshake.
- Words are emitted in ascending numeric order, using the next-same-popcount successor (Gosper step).
- Used to drive exhaustive stimulus into popcount and weight-based datapaths, and to enumerate fixed-weight code words.
- Output is a valid/ready stream with a last flag. Operation is start-triggered and abortable.

Parameters:
- N, 16, word width. Legal range 2..32. The target_count port is N bits wide, so a ones-count output from the counter feeds it directly.

Ports:
- clk  input  1  rising-edge clock (single clock domain).
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- target_count  input  N  K, the required number of ones; sampled on accepted start.
- abort  input  1  synchronous abort; returns to IDLE next edge.
- pattern  output  N  current word with exactly K ones.
- pattern_valid  output  1  pattern is valid.
- pattern_ready  input  1  downstream accepts the word when valid && ready.
- pattern_last  output  1  high with the final word of the sequence.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last word is accepted.
- err  output  1  one-cycle pulse when start is rejected because K > N.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE.
  - pattern=0; pattern_valid=0, pattern_last=0, busy=0, done=0, err=0.
  - Reset mid-sequence discards the sequence; no done pulse is produced.
- States are IDLE and RUN. done and err are registered pulses, not states.
- IDLE + start, K > N:
  - err=1 for one cycle; stay IDLE; no valid.
- IDLE + start, K ≤ N:
  - Enter RUN on the next edge.
  - pattern = low K bits set, i.e. (2^K)-1; pattern_valid=1; busy=1.
  - Latency from start to first valid is 1 cycle.
- Degenerate counts:
  - K=0 emits the single word 0 with pattern_last=1.
  - K=N emits the single word all-ones with pattern_last=1.
- Last word: pattern_last=1 exactly when pattern equals ((2^K)-1) << (N-K), the K ones packed at the MSB end.
- RUN, handshake on a non-last word:
  - Next edge loads the successor: c = x & -x; r = x + c; next = r | (((r ^ x) >> 2) >> ctz(x)).
  - ctz is the count of trailing zeros. No divider is used.
  - pattern_valid stays 1. Throughput is one word per cycle under continuous ready.
- RUN, handshake on the last word:
  - Next edge: IDLE; pattern_valid=0, pattern_last=0, busy=0; done=1 for one cycle.
  - pattern keeps its last value.
- Back-pressure: while valid && !ready, pattern and pattern_last hold stable.
- start while busy is ignored, and target_count is not resampled.
- A new start is accepted in the cycle done is high, because the FSM is already in IDLE.
- abort:
  - In RUN, the next edge goes to IDLE with valid=0, busy=0 and no done pulse.
  - abort takes priority over a handshake in the same cycle.
  - In IDLE, abort is a no-op and takes priority over start.
- Sequence length is exactly C(N,K) words, strictly increasing, each with popcount K.
- Arithmetic:
  - The successor computation uses N+1-bit internal width so r never overflows.
  - The last-word compare prevents stepping past the top word.

Test Plan:
- N=4, start with K=2, ready held 1 -> 6 words 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles. last only on 1100; done pulses the cycle after.
- N=16, K=8, random ready throttling -> 12870 words, strictly increasing, each popcount 8. First word 0x00FF, last word 0xFF00. Words are stable while stalled.
- N=16, K=0 and K=16 -> single words 0x0000 and 0xFFFF respectively, each with last=1, followed by a done pulse.
- N=16, K=17 -> err pulse for one cycle; pattern_valid stays 0; busy stays 0.
- N=16, K=3, abort asserted after 5 handshakes, with a handshake in the same cycle -> IDLE next edge, no done. A following start with K=1 yields 0x0001 … 0x8000 (16 words).
- N=16, K=4: assert rst asynchronously mid-stream -> outputs clear immediately without waiting for an edge. start re-pulsed with K=5 during an active run -> start ignored.
